// File: rtl/id_stage_pkg.sv
// Shared instruction encodings, next-PC select codes and the ID-stage decoder.
package id_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;

  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef enum logic [1:0] {
    PCSEL_PC4 = 2'b00,
    PCSEL_BEQ = 2'b01,
    PCSEL_J   = 2'b10,
    PCSEL_JR  = 2'b11
  } pcsel_e;

  typedef enum logic [3:0] {
    INS_NOP, INS_ADDU, INS_SUBU, INS_ORI, INS_LW, INS_SW,
    INS_BEQ, INS_LUI, INS_J, INS_JAL, INS_JR
  } ins_e;

  typedef struct packed {
    ins_e       kind;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
  } dec_t;

  // Unrecognised encodings fall through to INS_NOP.
  function automatic ins_e classify(input logic [31:0] instr);
    ins_e k;
    k = INS_NOP;
    case (instr[31:26])
      OP_SPECIAL: begin
        case (instr[5:0])
          FN_ADDU: k = INS_ADDU;
          FN_SUBU: k = INS_SUBU;
          FN_JR:   k = INS_JR;
          default: k = INS_NOP;
        endcase
      end
      OP_ORI:  k = INS_ORI;
      OP_LW:   k = INS_LW;
      OP_SW:   k = INS_SW;
      OP_BEQ:  k = INS_BEQ;
      OP_LUI:  k = INS_LUI;
      OP_J:    k = INS_J;
      OP_JAL:  k = INS_JAL;
      default: k = INS_NOP;
    endcase
    return k;
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.kind   = classify(instr);
    d.use_rs = d.kind inside {INS_ADDU, INS_SUBU, INS_ORI, INS_LW, INS_SW, INS_BEQ, INS_JR};
    d.use_rt = d.kind inside {INS_ADDU, INS_SUBU, INS_SW, INS_BEQ};
    case (d.kind)
      INS_ADDU, INS_SUBU:        d.dest = instr[15:11];
      INS_ORI, INS_LW, INS_LUI:  d.dest = instr[20:16];
      INS_JAL:                   d.dest = 5'd31;
      default:                   d.dest = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_grf.sv
// 32x32 register file; $0 reads zero, a same-cycle write is bypassed to the read ports.
module id_stage_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  // Register write; reset clears the whole array and wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && a3 != '0) begin
      regs[a3] <= wd;
    end
  end

  // Read ports with write-back bypass.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != '0) rd1 = (we && a3 == a1) ? wd : regs[a1];
    if (a2 != '0) rd2 = (we && a3 == a2) ? wd : regs[a2];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: register read, branch resolution with MEM forwarding, hazard stall, ID/EX register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC1,
  input  logic [31:0] Instr1,
  input  logic        WB_WE,
  input  logic [4:0]  WB_A3,
  input  logic [31:0] WB_WD,
  input  logic        MEM_WE,
  input  logic        MEM_IsLoad,
  input  logic [4:0]  MEM_A3,
  input  logic [31:0] MEM_WD,
  output logic [1:0]  PCSel,
  output logic [31:0] PC_j,
  output logic [31:0] PC_jr,
  output logic [31:0] PC_beq,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        IF_ID_Clr,
  output logic [31:0] PC2,
  output logic [31:0] Instr2,
  output logic [31:0] RD1_2,
  output logic [31:0] RD2_2,
  output logic [31:0] Ext2,
  output logic [4:0]  A3_2
);

  logic [4:0]  rs, rt;
  logic [15:0] imm;
  dec_t        id_dec;
  logic        ex_is_lw;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] br_a, br_b;
  logic [31:0] ext;
  logic        ex_hit, mem_hit, is_branchy, stall;
  pcsel_e      sel;

  assign rs       = Instr1[25:21];
  assign rt       = Instr1[20:16];
  assign imm      = Instr1[15:0];
  assign id_dec   = decode(Instr1);
  assign ex_is_lw = (classify(Instr2) == INS_LW);

  id_stage_grf u_grf (
    .clk   (clk),
    .reset (reset),
    .we    (WB_WE),
    .a1    (rs),
    .a2    (rt),
    .a3    (WB_A3),
    .wd    (WB_WD),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // Branch/jr operands: a non-load MEM result overrides the register-file read.
  always_comb begin
    br_a = rf_rd1;
    br_b = rf_rd2;
    if (MEM_WE && !MEM_IsLoad && MEM_A3 != '0 && MEM_A3 == rs) br_a = MEM_WD;
    if (MEM_WE && !MEM_IsLoad && MEM_A3 != '0 && MEM_A3 == rt) br_b = MEM_WD;
  end

  // Immediate extension by instruction type.
  always_comb begin
    case (id_dec.kind)
      INS_ORI: ext = {16'h0000, imm};
      INS_LUI: ext = {imm, 16'h0000};
      default: ext = {{16{imm[15]}}, imm};
    endcase
  end

  // Stall when a source is produced by an EX load, or when a branch/jr source is
  // still in flight in EX or is a MEM load result.
  always_comb begin
    ex_hit     = (A3_2 != '0) &&
                 ((id_dec.use_rs && rs == A3_2) || (id_dec.use_rt && rt == A3_2));
    mem_hit    = MEM_WE && MEM_IsLoad && (MEM_A3 != '0) &&
                 ((id_dec.use_rs && rs == MEM_A3) || (id_dec.use_rt && rt == MEM_A3));
    is_branchy = (id_dec.kind == INS_BEQ) || (id_dec.kind == INS_JR);
    stall      = (ex_is_lw && ex_hit) || (is_branchy && (ex_hit || mem_hit));
  end

  // Next-PC select; held at PC+4 while stalled.
  always_comb begin
    sel = PCSEL_PC4;
    if (!stall) begin
      case (id_dec.kind)
        INS_BEQ:        sel = (br_a == br_b) ? PCSEL_BEQ : PCSEL_PC4;
        INS_J, INS_JAL: sel = PCSEL_J;
        INS_JR:         sel = PCSEL_JR;
        default:        sel = PCSEL_PC4;
      endcase
    end
  end

  assign PCSel     = sel;
  assign PC_beq    = PC1 + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  assign PC_j      = {PC1[31:28], Instr1[25:0], 2'b00};
  assign PC_jr     = br_a;
  assign PC_En     = !stall;
  assign IF_ID_En  = !stall;
  assign IF_ID_Clr = 1'b0;

  // ID/EX pipeline register; a stall inserts a zero bubble.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      PC2    <= '0;
      Instr2 <= '0;
      RD1_2  <= '0;
      RD2_2  <= '0;
      Ext2   <= '0;
      A3_2   <= '0;
    end else begin
      PC2    <= PC1;
      Instr2 <= Instr1;
      RD1_2  <= rf_rd1;
      RD2_2  <= rf_rd2;
      Ext2   <= ext;
      A3_2   <= id_dec.dest;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized run against a reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC1, Instr1;
  logic        WB_WE;
  logic [4:0]  WB_A3;
  logic [31:0] WB_WD;
  logic        MEM_WE, MEM_IsLoad;
  logic [4:0]  MEM_A3;
  logic [31:0] MEM_WD;
  logic [1:0]  PCSel;
  logic [31:0] PC_j, PC_jr, PC_beq;
  logic        PC_En, IF_ID_En, IF_ID_Clr;
  logic [31:0] PC2, Instr2, RD1_2, RD2_2, Ext2;
  logic [4:0]  A3_2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .PC1(PC1), .Instr1(Instr1),
    .WB_WE(WB_WE), .WB_A3(WB_A3), .WB_WD(WB_WD),
    .MEM_WE(MEM_WE), .MEM_IsLoad(MEM_IsLoad), .MEM_A3(MEM_A3), .MEM_WD(MEM_WD),
    .PCSel(PCSel), .PC_j(PC_j), .PC_jr(PC_jr), .PC_beq(PC_beq),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .IF_ID_Clr(IF_ID_Clr),
    .PC2(PC2), .Instr2(Instr2), .RD1_2(RD1_2), .RD2_2(RD2_2), .Ext2(Ext2), .A3_2(A3_2)
  );

  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_ORI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_JR = 10;

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction
  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] mregs [32];
  logic [31:0] m_pc2, m_instr2, m_rd1, m_rd2, m_ext;
  logic [4:0]  m_a3;

  function automatic int mkind(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h21) return K_ADDU;
      if (fn == 6'h23) return K_SUBU;
      if (fn == 6'h08) return K_JR;
      return K_NOP;
    end
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    return K_NOP;
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    int k;
    bit s_used, t_used;
    k = mkind(ins);
    s_used = k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_JR};
    t_used = k inside {K_ADDU, K_SUBU, K_SW, K_BEQ};
    return (r != 0) && ((s_used && ins[25:21] == r) || (t_used && ins[20:16] == r));
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] ins);
    int k;
    k = mkind(ins);
    if (k == K_ADDU || k == K_SUBU) return ins[15:11];
    if (k == K_ORI || k == K_LW || k == K_LUI) return ins[20:16];
    if (k == K_JAL) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_extend(input logic [31:0] ins);
    int k;
    logic [15:0] im;
    k = mkind(ins);
    im = ins[15:0];
    if (k == K_ORI) return 32'(im);
    if (k == K_LUI) return {im, 16'h0000};
    return 32'($signed(im));
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (WB_WE && WB_A3 == r) return WB_WD;
    return mregs[r];
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (MEM_WE && !MEM_IsLoad && MEM_A3 == r && r != 0) return MEM_WD;
    return rf_read(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [15:0] im;
    int sel;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    sel = $urandom_range(0, 11);
    case (sel)
      0:  return r_type(6'h21, a, b, c);
      1:  return r_type(6'h23, a, b, c);
      2:  return i_type(6'h0D, a, b, im);
      3:  return i_type(6'h23, a, b, im);
      4:  return i_type(6'h2B, a, b, im);
      5:  return i_type(6'h04, a, b, im);
      6:  return i_type(6'h0F, 5'd0, b, im);
      7:  return j_type(6'h02, 26'($urandom));
      8:  return j_type(6'h03, 26'($urandom));
      9:  return r_type(6'h08, a, 5'd0, 5'd0);
      10: return i_type(6'h04, a, a, im);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PC1 = 32'd0; Instr1 = 32'd0;
    WB_WE = 1'b0; WB_A3 = 5'd0; WB_WD = 32'd0;
    MEM_WE = 1'b0; MEM_IsLoad = 1'b0; MEM_A3 = 5'd0; MEM_WD = 32'd0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    logic [164:0] idex;
    idle_inputs();
    reset = 1'b1;
    tick();
    Instr1 = j_type(6'h02, 26'h0000100);
    PC1 = 32'h0000_3000;
    WB_WE = 1'b1; WB_A3 = 5'd6; WB_WD = 32'hFFFF_0000;
    #1;
    n_checks++;
    if (PCSel !== 2'b10 || PC_En !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_comb: PCSel=%b PC_En=%b, required PCSel=10 PC_En=1", PCSel, PC_En);
    end
    tick();
    idex = {PC2, Instr2, RD1_2, RD2_2, Ext2, A3_2};
    n_checks++;
    if (idex !== '0) begin
      n_fail++;
      $display("FAIL reset_idex: got %h, required 0", idex);
    end
    reset = 1'b0;
    idle_inputs();
    Instr1 = r_type(6'h21, 5'd6, 5'd6, 5'd1);
    tick();
    n_checks++;
    if (RD1_2 !== 32'd0 || RD2_2 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: RD1_2=%h RD2_2=%h, required 0 0", RD1_2, RD2_2);
    end
  endtask

  task automatic test_wb_bypass();
    idle_inputs();
    PC1 = 32'h0000_3000;
    Instr1 = r_type(6'h21, 5'd5, 5'd0, 5'd7);
    WB_WE = 1'b1; WB_A3 = 5'd5; WB_WD = 32'h0000_1234;
    tick();
    n_checks++;
    if (RD1_2 !== 32'h0000_1234 || A3_2 !== 5'd7 || PC2 !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL wb_bypass: RD1_2=%h A3_2=%0d PC2=%h, required 00001234 7 00003000", RD1_2, A3_2, PC2);
    end
    WB_WE = 1'b0;
    Instr1 = r_type(6'h21, 5'd0, 5'd5, 5'd8);
    tick();
    n_checks++;
    if (RD2_2 !== 32'h0000_1234 || RD1_2 !== 32'd0) begin
      n_fail++;
      $display("FAIL wb_stored: RD1_2=%h RD2_2=%h, required 0 00001234", RD1_2, RD2_2);
    end
  endtask

  task automatic test_load_use();
    logic [164:0] idex;
    idle_inputs();
    Instr1 = i_type(6'h23, 5'd1, 5'd3, 16'h0000);
    tick();
    Instr1 = r_type(6'h21, 5'd3, 5'd1, 5'd4);
    #1;
    n_checks++;
    if (PC_En !== 1'b0 || IF_ID_En !== 1'b0 || PCSel !== 2'b00 || IF_ID_Clr !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_stall: PC_En=%b IF_ID_En=%b PCSel=%b Clr=%b, required 0 0 00 0",
               PC_En, IF_ID_En, PCSel, IF_ID_Clr);
    end
    tick();
    idex = {PC2, Instr2, RD1_2, RD2_2, Ext2, A3_2};
    n_checks++;
    if (idex !== '0) begin
      n_fail++;
      $display("FAIL load_use_bubble: got %h, required 0", idex);
    end
    #1;
    n_checks++;
    if (PC_En !== 1'b1 || IF_ID_En !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_release: PC_En=%b IF_ID_En=%b, required 1 1", PC_En, IF_ID_En);
    end
    tick();
    n_checks++;
    if (A3_2 !== 5'd4 || Instr2 !== r_type(6'h21, 5'd3, 5'd1, 5'd4)) begin
      n_fail++;
      $display("FAIL load_use_issue: A3_2=%0d Instr2=%h, required 4 %h", A3_2, Instr2, r_type(6'h21, 5'd3, 5'd1, 5'd4));
    end
  endtask

  task automatic test_beq_taken();
    idle_inputs();
    PC1 = 32'h0000_3004;
    Instr1 = i_type(6'h04, 5'd5, 5'd5, 16'hFFFE);
    #1;
    n_checks++;
    if (PCSel !== 2'b01 || PC_beq !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL beq_taken: PCSel=%b PC_beq=%h, required 01 00003000", PCSel, PC_beq);
    end
    Instr1 = i_type(6'h04, 5'd5, 5'd0, 16'hFFFE);
    #1;
    n_checks++;
    if (PCSel !== 2'b00 || PC_En !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_not_taken: PCSel=%b PC_En=%b, required 00 1", PCSel, PC_En);
    end
    tick();
  endtask

  task automatic test_beq_forward();
    idle_inputs();
    PC1 = 32'h0000_3008;
    Instr1 = i_type(6'h04, 5'd2, 5'd0, 16'h0003);
    MEM_WE = 1'b1; MEM_IsLoad = 1'b0; MEM_A3 = 5'd2; MEM_WD = 32'd7;
    #1;
    n_checks++;
    if (PCSel !== 2'b00 || PC_En !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_fwd_ne: PCSel=%b PC_En=%b, required 00 1", PCSel, PC_En);
    end
    Instr1 = i_type(6'h04, 5'd5, 5'd0, 16'h0003);
    MEM_A3 = 5'd5; MEM_WD = 32'd0;
    #1;
    n_checks++;
    if (PCSel !== 2'b01) begin
      n_fail++;
      $display("FAIL beq_fwd_priority: PCSel=%b, required 01", PCSel);
    end
    MEM_IsLoad = 1'b1;
    #1;
    n_checks++;
    if (PC_En !== 1'b0 || PCSel !== 2'b00) begin
      n_fail++;
      $display("FAIL beq_mem_load_stall: PC_En=%b PCSel=%b, required 0 00", PC_En, PCSel);
    end
    Instr1 = r_type(6'h08, 5'd5, 5'd0, 5'd0);
    MEM_IsLoad = 1'b0; MEM_WD = 32'h0000_4000;
    #1;
    n_checks++;
    if (PCSel !== 2'b11 || PC_jr !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL jr_fwd: PCSel=%b PC_jr=%h, required 11 00004000", PCSel, PC_jr);
    end
    MEM_WE = 1'b0;
    Instr1 = i_type(6'h0D, 5'd0, 5'd2, 16'h0001);
    tick();
    Instr1 = i_type(6'h04, 5'd2, 5'd0, 16'h0001);
    #1;
    n_checks++;
    if (PC_En !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_ex_stall: PC_En=%b, required 0", PC_En);
    end
    tick();
    #1;
    n_checks++;
    if (PC_En !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_ex_release: PC_En=%b, required 1", PC_En);
    end
  endtask

  task automatic test_jal();
    idle_inputs();
    PC1 = 32'h0000_3010;
    Instr1 = j_type(6'h03, 26'h0000C10);
    #1;
    n_checks++;
    if (PCSel !== 2'b10 || PC_j !== 32'h0000_3040) begin
      n_fail++;
      $display("FAIL jal_target: PCSel=%b PC_j=%h, required 10 00003040", PCSel, PC_j);
    end
    tick();
    n_checks++;
    if (A3_2 !== 5'd31 || PC2 !== 32'h0000_3010) begin
      n_fail++;
      $display("FAIL jal_dest: A3_2=%0d PC2=%h, required 31 00003010", A3_2, PC2);
    end
  endtask

  task automatic test_reset_during_stall();
    logic [164:0] idex;
    idle_inputs();
    Instr1 = i_type(6'h23, 5'd0, 5'd3, 16'h0010);
    tick();
    Instr1 = r_type(6'h21, 5'd3, 5'd0, 5'd4);
    #1;
    n_checks++;
    if (PC_En !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall_setup: PC_En=%b, required 0", PC_En);
    end
    reset = 1'b1;
    WB_WE = 1'b1; WB_A3 = 5'd9; WB_WD = 32'h0000_DEAD;
    tick();
    idex = {PC2, Instr2, RD1_2, RD2_2, Ext2, A3_2};
    n_checks++;
    if (idex !== '0) begin
      n_fail++;
      $display("FAIL rst_stall_idex: got %h, required 0", idex);
    end
    reset = 1'b0;
    idle_inputs();
    Instr1 = r_type(6'h21, 5'd9, 5'd5, 5'd1);
    tick();
    n_checks++;
    if (RD1_2 !== 32'd0 || RD2_2 !== 32'd0 || A3_2 !== 5'd1) begin
      n_fail++;
      $display("FAIL rst_stall_regs: RD1_2=%h RD2_2=%h A3_2=%0d, required 0 0 1", RD1_2, RD2_2, A3_2);
    end
  endtask

  // ---------------- randomized run ----------------
  task automatic test_random();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    m_pc2 = 0; m_instr2 = 0; m_rd1 = 0; m_rd2 = 0; m_ext = 0; m_a3 = 0;
    for (int c = 0; c < 800; c++) begin
      int k;
      bit br, e_stall;
      logic [1:0] e_sel;
      logic [31:0] e_beq, e_j, e_jr;
      logic [31:0] n_pc2, n_instr2, n_rd1, n_rd2, n_ext;
      logic [4:0] n_a3;
      PC1        = $urandom;
      Instr1     = rand_instr();
      WB_WE      = 1'($urandom_range(0, 1));
      WB_A3      = 5'($urandom_range(0, 7));
      WB_WD      = $urandom;
      MEM_WE     = 1'($urandom_range(0, 1));
      MEM_IsLoad = 1'($urandom_range(0, 1));
      MEM_A3     = 5'($urandom_range(0, 7));
      MEM_WD     = $urandom;
      reset      = ($urandom_range(0, 63) == 0);
      #1;
      k = mkind(Instr1);
      br = (k == K_BEQ) || (k == K_JR);
      e_stall = (mkind(m_instr2) == K_LW && reads_reg(Instr1, m_a3)) ||
                (br && reads_reg(Instr1, m_a3)) ||
                (br && MEM_WE && MEM_IsLoad && reads_reg(Instr1, MEM_A3));
      e_sel = 2'b00;
      if (!e_stall) begin
        if (k == K_BEQ && operand(Instr1[25:21]) == operand(Instr1[20:16])) e_sel = 2'b01;
        if (k == K_J || k == K_JAL) e_sel = 2'b10;
        if (k == K_JR) e_sel = 2'b11;
      end
      e_beq = PC1 + 32'd4 + 32'($signed(Instr1[15:0])) * 32'd4;
      e_j   = {PC1[31:28], Instr1[25:0], 2'b00};
      e_jr  = operand(Instr1[25:21]);
      n_checks++;
      if (PCSel !== e_sel || PC_En !== !e_stall || IF_ID_En !== !e_stall || IF_ID_Clr !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: PCSel=%b PC_En=%b IF_ID_En=%b Clr=%b, required %b %b %b 0 (instr %h)",
                 c, PCSel, PC_En, IF_ID_En, IF_ID_Clr, e_sel, !e_stall, !e_stall, Instr1);
      end
      n_checks++;
      if (PC_beq !== e_beq || PC_j !== e_j || PC_jr !== e_jr) begin
        n_fail++;
        $display("FAIL rand_targets[%0d]: beq=%h j=%h jr=%h, required %h %h %h",
                 c, PC_beq, PC_j, PC_jr, e_beq, e_j, e_jr);
      end
      if (reset || e_stall) begin
        n_pc2 = 0; n_instr2 = 0; n_rd1 = 0; n_rd2 = 0; n_ext = 0; n_a3 = 0;
      end else begin
        n_pc2 = PC1; n_instr2 = Instr1;
        n_rd1 = rf_read(Instr1[25:21]); n_rd2 = rf_read(Instr1[20:16]);
        n_ext = m_extend(Instr1); n_a3 = m_dest(Instr1);
      end
      tick();
      if (reset) begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else if (WB_WE && WB_A3 != 0) begin
        mregs[WB_A3] = WB_WD;
      end
      m_pc2 = n_pc2; m_instr2 = n_instr2; m_rd1 = n_rd1; m_rd2 = n_rd2; m_ext = n_ext; m_a3 = n_a3;
      n_checks++;
      if ({PC2, Instr2, RD1_2, RD2_2, Ext2, A3_2} !== {m_pc2, m_instr2, m_rd1, m_rd2, m_ext, m_a3}) begin
        n_fail++;
        $display("FAIL rand_idex[%0d]: got %h %h %h %h %h %h, required %h %h %h %h %h %h",
                 c, PC2, Instr2, RD1_2, RD2_2, Ext2, A3_2, m_pc2, m_instr2, m_rd1, m_rd2, m_ext, m_a3);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_wb_bypass();
    test_load_use();
    test_beq_taken();
    test_beq_forward();
    test_jal();
    test_reset_during_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
